// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between NUM_CONSUMERS load/store units. Requests
// are granted round-robin, starting at the consumer after the one that was
// served last. Only one memory transaction is in flight at a time. When a
// consumer has both a read and a write pending, its read goes first. Every
// output comes straight from a flop.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   consumer_read_valid        per-consumer read request
//   consumer_read_addr         per-consumer read address, packed (i*ADDR_BITS)
//   consumer_read_ready        per-consumer read completion, held until valid drops
//   consumer_read_data         per-consumer captured read data, packed (i*DATA_BITS)
//   consumer_write_valid       per-consumer write request
//   consumer_write_addr        per-consumer write address, packed
//   consumer_write_data        per-consumer write data, packed
//   consumer_write_ready       per-consumer write completion, held until valid drops
//   mem_read_valid/addr        read request to memory
//   mem_read_ready/data        memory read acknowledge and returned data
//   mem_write_valid/addr/data  write request to memory
//   mem_write_ready            memory write acknowledge
//   busy                       high whenever a grant is in progress
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8
) (
   input  logic                               clk,
   input  logic                               reset,

   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_addr,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,

   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_addr,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,

   output logic                               mem_write_valid,
   output logic [ADDR_BITS-1:0]               mem_write_addr,
   output logic [DATA_BITS-1:0]               mem_write_data,
   input  logic                               mem_write_ready,

   output logic                               busy
);

   localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NUM_CONSUMERS - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      RELAY
   } state_t;

   state_t              state;
   logic [PTR_BITS-1:0] rr_ptr;
   logic [PTR_BITS-1:0] grant_idx;
   logic                grant_is_read;

   logic                grant_found;
   logic [PTR_BITS-1:0] grant_sel;
   logic                relay_done;

   logic [ADDR_BITS-1:0] rd_addr_arr  [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0] wr_addr_arr  [NUM_CONSUMERS];
   logic [DATA_BITS-1:0] wr_data_arr  [NUM_CONSUMERS];
   logic [DATA_BITS-1:0] read_data_q  [NUM_CONSUMERS];

   // Split the flat per-consumer buses into arrays, and pack the captured
   // read data back out. The per-consumer read data lives in read_data_q,
   // so the packed output is still a flop output.
   for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_slices
      assign rd_addr_arr[g] = consumer_read_addr[g*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_arr[g] = consumer_write_addr[g*ADDR_BITS +: ADDR_BITS];
      assign wr_data_arr[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = read_data_q[g];
   end

   // Round-robin search. It starts at rr_ptr and wraps around, so the
   // consumer just served is checked last. The index is reduced by
   // subtraction rather than by a bit mask, so consumer counts that are not
   // a power of two also work.
   always_comb begin
      int                  idx;
      logic [PTR_BITS-1:0] cand;
      grant_found = 1'b0;
      grant_sel   = '0;
      idx         = 0;
      cand        = '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CONSUMERS) begin
            idx = idx - NUM_CONSUMERS;
         end
         cand = PTR_BITS'(idx);
         if (!grant_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
            grant_found = 1'b1;
            grant_sel   = cand;
         end
      end
   end

   // The relay phase ends once the granted consumer has dropped the valid
   // for the kind of request it was served on. Its other valid may still be
   // high, and that request waits for a later grant.
   always_comb begin
      relay_done = 1'b0;
      if (grant_is_read) begin
         relay_done = !consumer_read_valid[grant_idx];
      end else begin
         relay_done = !consumer_write_valid[grant_idx];
      end
   end

   // Main controller. A grant, or a memory acknowledge, moves the FSM and
   // updates every affected output on the same edge. The request fields and
   // the mem_*_valid outputs are loaded only when a grant is made. Nothing
   // in the wait states changes them, so they stay stable however long the
   // memory stalls and whatever the consumer does with its valid. A memory
   // ready is only examined in its matching wait state, so a stray
   // acknowledge in any other state has no effect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         rr_ptr               <= '0;
         grant_idx            <= '0;
         grant_is_read        <= 1'b0;
         busy                 <= 1'b0;
         mem_read_valid       <= 1'b0;
         mem_read_addr        <= '0;
         mem_write_valid      <= 1'b0;
         mem_write_addr       <= '0;
         mem_write_data       <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         for (int i = 0; i < NUM_CONSUMERS; i++) begin
            read_data_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  grant_idx <= grant_sel;
                  busy      <= 1'b1;
                  if (consumer_read_valid[grant_sel]) begin
                     grant_is_read  <= 1'b1;
                     mem_read_addr  <= rd_addr_arr[grant_sel];
                     mem_read_valid <= 1'b1;
                     state          <= READ_WAIT;
                  end else begin
                     grant_is_read   <= 1'b0;
                     mem_write_addr  <= wr_addr_arr[grant_sel];
                     mem_write_data  <= wr_data_arr[grant_sel];
                     mem_write_valid <= 1'b1;
                     state           <= WRITE_WAIT;
                  end
               end
            end

            READ_WAIT: begin
               if (mem_read_ready) begin
                  mem_read_valid                 <= 1'b0;
                  read_data_q[grant_idx]         <= mem_read_data;
                  consumer_read_ready[grant_idx] <= 1'b1;
                  state                          <= RELAY;
               end
            end

            WRITE_WAIT: begin
               if (mem_write_ready) begin
                  mem_write_valid                 <= 1'b0;
                  consumer_write_ready[grant_idx] <= 1'b1;
                  state                           <= RELAY;
               end
            end

            RELAY: begin
               if (relay_done) begin
                  consumer_read_ready  <= '0;
                  consumer_write_ready <= '0;
                  rr_ptr               <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                  busy                 <= 1'b0;
                  state                <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter with four consumers and 8-bit address
// and data. The bench plays the memory side by hand. Single transactions
// come from a table of records that hold the expected results. Round-robin
// order, a consumer with both requests pending, reset in the middle of a
// transaction, a stalled memory and stray acknowledges each get their own
// hand-written sequence.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    consumer_read_valid;
   logic [N*AW-1:0] consumer_read_addr;
   logic [N-1:0]    consumer_read_ready;
   logic [N*DW-1:0] consumer_read_data;
   logic [N-1:0]    consumer_write_valid;
   logic [N*AW-1:0] consumer_write_addr;
   logic [N*DW-1:0] consumer_write_data;
   logic [N-1:0]    consumer_write_ready;
   logic            mem_read_valid;
   logic [AW-1:0]   mem_read_addr;
   logic            mem_read_ready;
   logic [DW-1:0]   mem_read_data;
   logic            mem_write_valid;
   logic [AW-1:0]   mem_write_addr;
   logic [DW-1:0]   mem_write_data;
   logic            mem_write_ready;
   logic            busy;

   int test_count;
   int fail_count;

   mem_arbiter #(
      .NUM_CONSUMERS(N),
      .ADDR_BITS    (AW),
      .DATA_BITS    (DW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .consumer_read_valid (consumer_read_valid),
      .consumer_read_addr  (consumer_read_addr),
      .consumer_read_ready (consumer_read_ready),
      .consumer_read_data  (consumer_read_data),
      .consumer_write_valid(consumer_write_valid),
      .consumer_write_addr (consumer_write_addr),
      .consumer_write_data (consumer_write_data),
      .consumer_write_ready(consumer_write_ready),
      .mem_read_valid      (mem_read_valid),
      .mem_read_addr       (mem_read_addr),
      .mem_read_ready      (mem_read_ready),
      .mem_read_data       (mem_read_data),
      .mem_write_valid     (mem_write_valid),
      .mem_write_addr      (mem_write_addr),
      .mem_write_data      (mem_write_data),
      .mem_write_ready     (mem_write_ready),
      .busy                (busy)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One record per isolated transaction. For a read, data is what memory
   // returns and exp_data is the expected consumer_read_data slice. For a
   // write, data is the consumer's write data and exp_data is the expected
   // mem_write_data. exp_mask is the expected one-hot ready vector.
   typedef struct {
      int         consumer;
      bit         is_read;
      logic [7:0] addr;
      logic [7:0] data;
      int         delay;
      logic [7:0] exp_addr;
      logic [7:0] exp_data;
      logic [3:0] exp_mask;
   } vec_t;

   vec_t vectors [5];

   // Inputs change and outputs are sampled on the falling edge, half a
   // cycle away from the rising edge the DUT acts on.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      consumer_read_valid  = '0;
      consumer_read_addr   = '0;
      consumer_write_valid = '0;
      consumer_write_addr  = '0;
      consumer_write_data  = '0;
      mem_read_ready       = 1'b0;
      mem_read_data        = '0;
      mem_write_ready      = 1'b0;
   endtask

   task automatic applyReset();
      clearInputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Runs one complete transaction from a table record: request, grant,
   // memory wait, acknowledge, relay, then release by the consumer.
   task automatic applyStimulus(input vec_t v, input string tag);
      int c;
      c = v.consumer;
      if (v.is_read) begin
         consumer_read_valid[c]         = 1'b1;
         consumer_read_addr[c*AW +: AW] = v.addr;
      end else begin
         consumer_write_valid[c]         = 1'b1;
         consumer_write_addr[c*AW +: AW] = v.addr;
         consumer_write_data[c*DW +: DW] = v.data;
      end
      tick();
      if (v.is_read) begin
         checkOutput({tag, " grant rd {valid,wvalid,addr}"},
                     {mem_read_valid, mem_write_valid, mem_read_addr},
                     {1'b1, 1'b0, v.exp_addr});
      end else begin
         checkOutput({tag, " grant wr {wvalid,rvalid,addr,data}"},
                     {mem_write_valid, mem_read_valid, mem_write_addr, mem_write_data},
                     {1'b1, 1'b0, v.exp_addr, v.exp_data});
      end
      for (int d = 0; d < v.delay; d++) begin
         tick();
      end
      checkOutput({tag, " busy while waiting"}, busy, 1'b1);
      if (v.is_read) begin
         mem_read_ready = 1'b1;
         mem_read_data  = v.data;
      end else begin
         mem_write_ready = 1'b1;
      end
      tick();
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = 8'h00;
      if (v.is_read) begin
         checkOutput({tag, " rd ready mask"}, {consumer_write_ready, consumer_read_ready},
                     {4'h0, v.exp_mask});
         checkOutput({tag, " rd data slice"}, consumer_read_data[c*DW +: DW], v.exp_data);
         checkOutput({tag, " mem_read_valid cleared"}, mem_read_valid, 1'b0);
      end else begin
         checkOutput({tag, " wr ready mask"}, {consumer_read_ready, consumer_write_ready},
                     {4'h0, v.exp_mask});
         checkOutput({tag, " mem_write_valid cleared"}, mem_write_valid, 1'b0);
      end
      tick();
      checkOutput({tag, " ready held"}, consumer_read_ready | consumer_write_ready, v.exp_mask);
      consumer_read_valid[c]  = 1'b0;
      consumer_write_valid[c] = 1'b0;
      tick();
      checkOutput({tag, " release {busy,readies}"},
                  {busy, consumer_read_ready, consumer_write_ready}, 9'h000);
   endtask

   initial begin
      test_count = 0;
      fail_count = 0;
      reset      = 1'b0;
      clearInputs();

      //             cons rd   addr   data   dly  exp_a  exp_d  mask
      vectors[0] = '{2,   1'b1, 8'h3C, 8'hA5, 3,   8'h3C, 8'hA5, 4'b0100};
      vectors[1] = '{0,   1'b0, 8'h10, 8'h7E, 0,   8'h10, 8'h7E, 4'b0001};
      vectors[2] = '{3,   1'b1, 8'hFF, 8'h00, 0,   8'hFF, 8'h00, 4'b1000};
      vectors[3] = '{1,   1'b0, 8'h00, 8'hFF, 5,   8'h00, 8'hFF, 4'b0010};
      vectors[4] = '{0,   1'b1, 8'h81, 8'h5A, 1,   8'h81, 8'h5A, 4'b0001};

      // Reset state
      applyReset();
      checkOutput("reset {busy,rvalid,wvalid}", {busy, mem_read_valid, mem_write_valid}, 3'b000);
      checkOutput("reset readies", {consumer_read_ready, consumer_write_ready}, 8'h00);
      checkOutput("reset mem addr/data", {mem_read_addr, mem_write_addr, mem_write_data}, 24'h0);
      checkOutput("reset read data", consumer_read_data, 32'h0);

      // Table of isolated transactions
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vectors[i], $sformatf("vec%0d", i));
      end
      checkOutput("read data retained", consumer_read_data, 32'h00_A5_00_5A);

      // Stray memory acknowledges outside the matching wait state
      applyReset();
      mem_read_ready  = 1'b1;
      mem_write_ready = 1'b1;
      tick();
      checkOutput("stray ack in idle", {busy, consumer_read_ready, consumer_write_ready}, 9'h000);
      clearInputs();
      consumer_read_valid[0]   = 1'b1;
      consumer_read_addr[7:0]  = 8'h42;
      tick();
      mem_write_ready = 1'b1;
      tick();
      mem_write_ready = 1'b0;
      checkOutput("wrong ack in read wait",
                  {busy, mem_read_valid, consumer_read_ready, consumer_write_ready}, 10'h300);

      // Round robin: everyone asks at once, consumer 0 asks again at once
      applyReset();
      consumer_read_valid = 4'hF;
      consumer_read_addr  = 32'h43_42_41_40;
      begin
         int order [5];
         order = '{0, 1, 2, 3, 0};
         for (int s = 0; s < 5; s++) begin
            int g;
            g = order[s];
            tick();
            checkOutput($sformatf("rr step%0d grant addr", s), mem_read_addr, 32'h40 + g);
            mem_read_ready = 1'b1;
            mem_read_data  = 8'h90 + 8'(s);
            tick();
            mem_read_ready = 1'b0;
            checkOutput($sformatf("rr step%0d ready", s), consumer_read_ready, 32'h1 << g);
            checkOutput($sformatf("rr step%0d data", s), consumer_read_data[g*DW +: DW],
                        32'h90 + s);
            consumer_read_valid[g] = 1'b0;
            tick();
            checkOutput($sformatf("rr step%0d release", s), {busy, consumer_read_ready}, 5'h00);
            if (s == 0) begin
               consumer_read_valid[0] = 1'b1;
            end
         end
      end

      // Consumer 1 has a read and a write pending: read first, then idle, then write
      applyReset();
      consumer_read_valid[1]   = 1'b1;
      consumer_write_valid[1]  = 1'b1;
      consumer_read_addr[15:8]  = 8'h22;
      consumer_write_addr[15:8] = 8'h33;
      consumer_write_data[15:8] = 8'h44;
      tick();
      checkOutput("rw read first", {mem_read_valid, mem_write_valid, mem_read_addr}, 10'h222);
      mem_read_ready = 1'b1;
      mem_read_data  = 8'h66;
      tick();
      mem_read_ready = 1'b0;
      checkOutput("rw read ready", {consumer_read_ready, consumer_write_ready}, 8'h20);
      consumer_read_valid[1] = 1'b0;
      tick();
      checkOutput("rw idle between", {busy, mem_write_valid, consumer_read_ready}, 6'h00);
      tick();
      checkOutput("rw write grant", {mem_write_valid, mem_write_addr, mem_write_data}, 17'h13344);
      mem_write_ready = 1'b1;
      tick();
      mem_write_ready = 1'b0;
      checkOutput("rw write ready", {consumer_read_ready, consumer_write_ready}, 8'h02);
      checkOutput("rw read data kept", consumer_read_data[15:8], 8'h66);
      consumer_write_valid[1] = 1'b0;
      tick();
      checkOutput("rw write release", {busy, consumer_write_ready}, 5'h00);

      // Reset during consumer 3's read wait, after consumer 1 has moved rr_ptr to 2
      applyReset();
      applyStimulus('{1, 1'b1, 8'h11, 8'h22, 0, 8'h11, 8'h22, 4'b0010}, "pre-reset");
      consumer_read_valid[3]    = 1'b1;
      consumer_read_addr[31:24] = 8'h77;
      tick();
      checkOutput("mid grant c3", {mem_read_valid, mem_read_addr}, 9'h177);
      consumer_read_valid[0]   = 1'b1;
      consumer_read_addr[7:0]  = 8'h05;
      reset          = 1'b1;
      mem_read_ready = 1'b1;
      mem_read_data  = 8'hEE;
      #1;
      checkOutput("async reset outputs",
                  {busy, mem_read_valid, mem_read_addr, consumer_read_ready, consumer_write_ready},
                  18'h0);
      checkOutput("async reset read data", consumer_read_data, 32'h0);
      tick();
      reset          = 1'b0;
      mem_read_ready = 1'b0;
      tick();
      checkOutput("post reset grant c0", {mem_read_valid, mem_read_addr}, 9'h105);
      checkOutput("no stale ready", {consumer_read_ready, consumer_write_ready}, 8'h00);

      // Memory stalls for 20 cycles while everyone else queues up
      applyReset();
      consumer_read_valid[1]   = 1'b1;
      consumer_read_addr[15:8] = 8'h5B;
      tick();
      consumer_read_valid[0]    = 1'b1;
      consumer_read_valid[3]    = 1'b1;
      consumer_write_valid[2]   = 1'b1;
      consumer_write_addr[23:16] = 8'hB2;
      consumer_write_data[23:16] = 8'h2B;
      for (int s = 0; s < 20; s++) begin
         tick();
         checkOutput($sformatf("stall cycle%0d", s),
                     {mem_read_valid, mem_write_valid, mem_read_addr,
                      consumer_read_ready, consumer_write_ready},
                     {1'b1, 1'b0, 8'h5B, 4'h0, 4'h0});
      end
      mem_read_ready = 1'b1;
      mem_read_data  = 8'hC3;
      tick();
      mem_read_ready = 1'b0;
      checkOutput("stall ready c1", consumer_read_ready, 4'b0010);
      checkOutput("stall data c1", consumer_read_data[15:8], 8'hC3);
      consumer_read_valid[1] = 1'b0;
      tick();
      tick();
      checkOutput("stall next grant c2 write", {mem_write_valid, mem_read_valid, mem_write_addr},
                  10'h2B2);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
